// File: rtl/spi_byte_sequencer_pkg.sv
// Shared types and constants for the SPI byte sequencer: FSM states,
// chip-select codes and the command word layout.
package spi_byte_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } seq_state_e;

  localparam logic [2:0] CS_SD    = 3'b100;
  localparam logic [2:0] CS_FLASH = 3'b010;
  localparam logic [2:0] CS_LCD   = 3'b001;
  localparam logic [2:0] CS_NONE  = 3'b000;

  // Command word: {cs[2:0], c_d, byte[7:0]}
  localparam int unsigned WR_BYTE_LSB = 0;
  localparam int unsigned WR_CD_BIT   = 8;
  localparam int unsigned WR_CS_LSB   = 9;
  localparam int unsigned WR_WIDTH    = 12;
  localparam int unsigned RD_WIDTH    = 8;

  typedef struct packed {
    logic [2:0] cs;
    logic       c_d;
    logic [7:0] data;
  } cmd_t;

endpackage

// File: rtl/spi_byte_sequencer_if.sv
// Producer/consumer bus of the SPI byte sequencer: command write channel
// and received-byte read channel.
interface spi_byte_sequencer_if;
  import spi_byte_sequencer_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  logic [WR_WIDTH-1:0] wr_data;
  logic                rd_valid;
  logic                rd_ready;
  logic [RD_WIDTH-1:0] rd_data;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/spi_byte_sequencer_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with synchronous flush and an
// occupancy output. Pointers carry one extra bit to tell full from empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push_ok, pop_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level    = wr_ptr_q - rd_ptr_q;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok   = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop_ok);

  // Next pointer/storage state; flush overrides any push or pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: queues tagged command bytes and feeds them one at a
// time to the SPI byte engine via start/done, collecting MISO bytes.
// Build option: define SPI_SEQ_RX_EN to include the receive FIFO, the rd_*
// handshake and rx_overflow; otherwise the block is write-only.
module spi_byte_sequencer
  import spi_byte_sequencer_pkg::*;
#(
  parameter int unsigned TX_DEPTH   = 16,
  parameter int unsigned RX_DEPTH   = 16,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Resetn,
  spi_byte_sequencer_if.slave       bus,
  input  logic                      flush,
  input  logic                      ovf_clr,
  output logic                      spi_start,
  output logic [7:0]                spi_data_in,
  output logic [2:0]                spi_cs,
  output logic                      spi_c_d,
  input  logic                      spi_done,
  input  logic [7:0]                spi_data_out,
  output logic                      busy,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic                      rx_overflow
);

  localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  cmd_t       tx_head;
  logic       tx_full, tx_empty, tx_push, tx_pop;
  logic       rx_push;

  seq_state_e state_q, state_d;
  logic       start_q, start_d;
  logic [7:0] data_q, data_d;
  logic [2:0] cs_q, cs_d;
  logic       cd_q, cd_d;
  logic [7:0] gap_q, gap_d;
  logic       discard_q, discard_d;

  assign bus.wr_ready = !tx_full;
  assign tx_push      = bus.wr_valid && !tx_full;

  sync_fifo #(
    .WIDTH (WR_WIDTH),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (Bus2IP_Clk),
    .rst_n     (Bus2IP_Resetn),
    .flush     (flush),
    .push      (tx_push),
    .push_data (bus.wr_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  assign spi_start   = start_q;
  assign spi_data_in = data_q;
  assign spi_cs      = cs_q;
  assign spi_c_d     = cd_q;
  assign busy        = (state_q != ST_IDLE) || !tx_empty;

  // Sequencer next state: load, issue, wait for done, then idle gap.
  // A flush after the start pulse marks the in-flight byte for discard.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    data_d    = data_q;
    cs_d      = cs_q;
    cd_d      = cd_q;
    gap_d     = gap_q;
    discard_d = discard_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (tx_empty || flush) begin
          state_d = ST_IDLE;
          cs_d    = CS_NONE;
        end else begin
          tx_pop  = 1'b1;
          data_d  = tx_head.data;
          cs_d    = tx_head.cs;
          cd_d    = tx_head.c_d;
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        if (flush) discard_d = 1'b1;
      end
      ST_WAIT: begin
        if (flush) discard_d = 1'b1;
        if (spi_done) begin
          rx_push   = !discard_q && !flush;
          discard_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
            if (tx_empty || flush) cs_d = CS_NONE;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          if (tx_empty || flush) cs_d = CS_NONE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_d    = CS_NONE;
      end
    endcase
  end

  // Sequencer state and registered engine outputs.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      data_q    <= '0;
      cs_q      <= CS_NONE;
      cd_q      <= 1'b0;
      gap_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      data_q    <= data_d;
      cs_q      <= cs_d;
      cd_q      <= cd_d;
      gap_q     <= gap_d;
      discard_q <= discard_d;
    end
  end

`ifdef SPI_SEQ_RX_EN
  logic                       rx_full, rx_empty, rx_pop;
  logic                       ovf_q, ovf_d;
  logic [$clog2(RX_DEPTH):0]  rx_level_unused;

  assign bus.rd_valid = !rx_empty;
  assign rx_pop       = !rx_empty && bus.rd_ready;
  assign rx_overflow  = ovf_q;

  sync_fifo #(
    .WIDTH (RD_WIDTH),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (Bus2IP_Clk),
    .rst_n     (Bus2IP_Resetn),
    .flush     (flush),
    .push      (rx_push),
    .push_data (spi_data_out),
    .pop       (rx_pop),
    .pop_data  (bus.rd_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level_unused)
  );

  // Sticky overflow: a dropped byte sets it, and setting beats clearing.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (rx_push && rx_full && !rx_pop) ovf_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) ovf_q <= 1'b0;
    else                ovf_q <= ovf_d;
  end
`else
  logic unused_rx;

  assign bus.rd_valid = 1'b0;
  assign bus.rd_data  = '0;
  assign rx_overflow  = 1'b0;
  assign unused_rx    = ^{spi_data_out, ovf_clr, bus.rd_ready, rx_push};
`endif

endmodule
